serpentine_pair_packer: RTL and testbench
=========================================

Name: serpentine_pair_packer

Overview:
Packs a serpentine-ordered DRAM pixel stream into 16-bit-per-channel pair words and generates FSRAM write addresses. It is the parametrised successor of the fixed top/middle-section write path.
- Width, channel count and frame size are generalised.
- Mode is selectable: horizontal pairs or vertical (row-pair) packing.
- Valid/ready backpressure is added on both sides.
- Sits between the DRAM read stream and the FSRAM port-A write interface.

Parameters:
DATA_W, 8, bits per pixel per channel
CH, 4, channels per input beat
ROW, 16, frame rows (must be even)
COL, 16, frame columns (must be even)
ADDR_W, 12, FSRAM address width (ROW*COL/2 <= 2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
mode  in  1  0 = horizontal pairs, 1 = vertical pairs; latched on accepted start
in_valid  in  1  input pixel beat valid
in_ready  out  1  block accepts beat
in_data  in  CH*DATA_W  one pixel for CH channels; lane i = [i*DATA_W +: DATA_W]
out_valid  out  1  packed word valid
out_ready  in  1  FSRAM side accepts word
out_addr  out  ADDR_W  FSRAM word address
out_data  out  CH*2*DATA_W  lane i = [i*2*DATA_W +: 2*DATA_W] = {first_i, second_i}
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last word handshake

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; all counters, the pending register and the line buffer valid flag are cleared.
  - in_ready=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
  - A reset mid-frame discards all partial data; no word is emitted afterwards.
- FSM: IDLE -(start)-> RUN -(last word accepted)-> DONE -> IDLE.
  - DONE lasts exactly 1 cycle with done=1.
  - start in RUN or DONE is ignored.
- Input order:
  - Row r even: columns 0..COL-1.
  - Row r odd: columns COL-1..0.
  - Row and column counters plus a direction bit track position; the direction toggles at each row end.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A beat transfers when in_valid && in_ready.
  - Output is a 1-deep register. out_addr/out_data are held stable while out_valid && !out_ready.
  - out_valid drops the cycle after a handshake unless a new word is produced in the same cycle.
  - Simultaneous output handshake and new-word production is allowed at full throughput.
- Horizontal mode (mode=0):
  - The first pixel of each in-row pair is held in the pending register. The second pixel produces a word on the next posedge (1-cycle latency).
  - Word = {first, second} per lane, so odd rows give {pix[c], pix[c-1]}.
  - out_addr = r*(COL/2) + min(c_first, c_second)/2.
  - Pairs never straddle rows, because COL is even.
- Vertical mode (mode=1):
  - Even row 2k: pixels are stored into line buffer entry c; no output.
  - Odd row 2k+1: the pixel at column c produces word {buf[c], pix} per lane, with out_addr = k*COL + c, 1-cycle latency.
- Frame length: both modes produce exactly ROW*COL/2 words.
  - The last input beat is (ROW-1, col 0).
  - in_ready=0 once all ROW*COL beats have been taken.
- Arithmetic:
  - Address arithmetic is unsigned, computed at ADDR_W width.
  - No wrap within a legal frame. Counters wrap to 0 only on a new start.

Test Plan:
- Horizontal, CH=1, ROW=4, COL=4, pixel=16*r+c, out_ready=1 -> 8 words in order:
  - (addr 0, 0x0001), (1, 0x0203)
  - (3, 0x1312), (2, 0x1110)
  - (4, 0x2021), (5, 0x2223)
  - (7, 0x3332), (6, 0x3130)
  - then done pulses once.
- Vertical, same stream -> no output during rows 0 and 2. Words in order:
  - (addr 3, 0x0313), (2, 0x0212), (1, 0x0111), (0, 0x0010)
  - (7, 0x2333), (6, 0x2232), (5, 0x2131), (4, 0x2030)
  - then done.
- Backpressure: horizontal, out_ready=0 for 5 cycles after the first word:
  - out_data=0x0001 and addr=0 are held stable.
  - in_ready=0 after the next pair completes.
  - No beat is lost; the final word sequence is identical to the first scenario.
- CH=2, lanes {0x10+p, p}, horizontal -> first word out_data = {0x1011, 0x0001} (lane1, lane0).
- start pulsed while busy=1 -> ignored; the frame completes normally with exactly 8 words and one done.
- rst_n=0 for 1 cycle after 3 words:
  - All outputs are 0 the next cycle; out_valid stays 0.
  - A fresh start replays the frame from addr 0 with correct words.

Source files
------------

// File: rtl/serpentine_pair_packer_if.sv
// Stream bundle between the DRAM pixel reader, the pair packer and the FSRAM port-A writer.
// The packer takes the slave view; the pixel source / FSRAM sink side takes the master view.
interface serpentine_pair_packer_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int ADDR_W = 12
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CH*DATA_W-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_W-1:0]      out_addr;
    logic [CH*2*DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/serpentine_pair_packer.sv
// Packs a serpentine-ordered pixel stream into {first, second} pair words (horizontal or
// vertical pairing) and generates the matching FSRAM word addresses.
//
//   state  | meaning
//   IDLE   | waiting for start; mode is latched when start is accepted
//   RUN    | taking beats, producing pair words into the 1-deep output register
//   DONE   | one-cycle done pulse after the last word handshake
module serpentine_pair_packer #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int ROW    = 16,
    parameter int COL    = 16,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    serpentine_pair_packer_if.slave bus,
    output logic                    busy,
    output logic                    done
);
    localparam int PW = CH * DATA_W;
    localparam int OW = CH * 2 * DATA_W;
    localparam int CW = (COL > 2) ? $clog2(COL) : 1;
    localparam int RW = (ROW > 2) ? $clog2(ROW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              dir_q, dir_d;
    logic              in_done_q, in_done_d;
    logic              lb_vld_q, lb_vld_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [PW-1:0]     lb_q [COL];
    logic [PW-1:0]     lb_d [COL];
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [OW-1:0]     out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_ready_w;
    logic              beat;
    logic              hs_out;
    logic              first;
    logic              row_end;
    logic              emit;
    logic [PW-1:0]     first_pix;
    logic [ADDR_W-1:0] new_addr;

    assign in_ready_w = (state_q == S_RUN) && !in_done_q && (!out_valid_q || bus.out_ready);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        dir_d       = dir_q;
        in_done_d   = in_done_q;
        lb_vld_d    = lb_vld_q;
        pend_d      = pend_q;
        lb_d        = lb_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        emit        = 1'b0;
        first_pix   = '0;
        new_addr    = '0;

        beat    = bus.in_valid && in_ready_w;
        hs_out  = out_valid_q && bus.out_ready;
        // dir_q tracks row parity, so the first pixel of a pair sits where col[0] equals it
        first   = (col_q[0] == dir_q);
        row_end = dir_q ? (col_q == '0) : (col_q == COL_LAST);

        if (hs_out) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    mode_d     = mode;
                    row_d      = '0;
                    col_d      = '0;
                    dir_d      = 1'b0;
                    in_done_d  = 1'b0;
                    lb_vld_d   = 1'b0;
                    out_last_d = 1'b0;
                end
            end
            S_RUN: begin
                if (hs_out && out_last_q) state_d = S_DONE;
                if (beat) begin
                    if (row_end) begin
                        row_d = row_q + RW'(1);
                        dir_d = !dir_q;
                        if (row_q == ROW_LAST) in_done_d = 1'b1;
                    end else if (dir_q) begin
                        col_d = col_q - CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end

                    if (!mode_q) begin
                        if (first) begin
                            pend_d = bus.in_data;
                        end else begin
                            emit      = 1'b1;
                            first_pix = pend_q;
                            new_addr  = ADDR_W'(row_q) * ADDR_W'(COL / 2) + ADDR_W'(col_q >> 1);
                        end
                    end else if (!dir_q) begin
                        lb_d[col_q] = bus.in_data;
                        if (row_end) lb_vld_d = 1'b1;
                    end else if (lb_vld_q) begin
                        emit      = 1'b1;
                        first_pix = lb_q[col_q];
                        new_addr  = ADDR_W'(row_q >> 1) * ADDR_W'(COL) + ADDR_W'(col_q);
                        if (row_end) lb_vld_d = 1'b0;
                    end

                    if (emit) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = new_addr;
                        out_last_d  = row_end && (row_q == ROW_LAST);
                        for (int i = 0; i < CH; i++) begin
                            out_data_d[i*2*DATA_W +: 2*DATA_W] =
                                {first_pix[i*DATA_W +: DATA_W], bus.in_data[i*DATA_W +: DATA_W]};
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            dir_q       <= 1'b0;
            in_done_q   <= 1'b0;
            lb_vld_q    <= 1'b0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dir_q       <= dir_d;
            in_done_q   <= in_done_d;
            lb_vld_q    <= lb_vld_d;
            pend_q      <= pend_d;
            lb_q        <= lb_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_serpentine_pair_packer.sv
// Directed bench for serpentine_pair_packer on a 4x4 frame: horizontal, vertical,
// backpressure, ignored start, mid-frame reset, and a two-channel lane check.
module tb_serpentine_pair_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, mode = 1'b0, busy, done;
    logic start2 = 1'b0, mode2 = 1'b0, busy2, done2;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serpentine_pair_packer_if #(.DATA_W(8), .CH(1), .ADDR_W(12)) bus1 ();
    serpentine_pair_packer_if #(.DATA_W(8), .CH(2), .ADDR_W(12)) bus2 ();

    serpentine_pair_packer #(.DATA_W(8), .CH(1), .ROW(4), .COL(4), .ADDR_W(12)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bus(bus1.slave),
        .busy(busy), .done(done));

    serpentine_pair_packer #(.DATA_W(8), .CH(2), .ROW(4), .COL(4), .ADDR_W(12)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .bus(bus2.slave),
        .busy(busy2), .done(done2));

    logic [11:0] exp_h_addr [8] = '{12'd0, 12'd1, 12'd3, 12'd2, 12'd4, 12'd5, 12'd7, 12'd6};
    logic [15:0] exp_h_data [8] = '{16'h0001, 16'h0203, 16'h1312, 16'h1110,
                                    16'h2021, 16'h2223, 16'h3332, 16'h3130};
    logic [11:0] exp_v_addr [8] = '{12'd3, 12'd2, 12'd1, 12'd0, 12'd7, 12'd6, 12'd5, 12'd4};
    logic [15:0] exp_v_data [8] = '{16'h0313, 16'h0212, 16'h0111, 16'h0010,
                                    16'h2333, 16'h2232, 16'h2131, 16'h2030};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int idx);
        int r, j, c;
        r = idx / 4;
        j = idx % 4;
        c = (r % 2 == 0) ? j : 3 - j;
        return 8'(16 * r + c);
    endfunction

    // Runs one frame on u1. bp!=0 stalls out_ready for 5 cycles at the first word;
    // start_at pulses start when that beat index is offered; stop_words!=0 returns early.
    task automatic run_frame(input logic m, input int bp, input int start_at, input int stop_words);
        int idx, nw, stall, ndone, extra;
        bit seen_first, finished;
        idx = 0; nw = 0; stall = 0; ndone = 0; extra = 0;
        seen_first = 0; finished = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode  = !m;
        chk("busy_after_start", busy, 1'b1);
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            start = (idx == start_at);
            if (bp != 0 && !seen_first && bus1.out_valid) begin
                seen_first = 1;
                stall = 5;
            end
            bus1.out_ready = (stall == 0);
            bus1.in_valid  = (idx < 16);
            bus1.in_data   = pix(idx);
            #1;
            if (stall > 0) begin
                chk("bp_hold_valid", bus1.out_valid, 1'b1);
                chk("bp_hold_addr", bus1.out_addr, 12'd0);
                chk("bp_hold_data", bus1.out_data, 16'h0001);
                chk("bp_in_ready", bus1.in_ready, 1'b0);
                stall--;
            end
            if (bus1.out_valid && bus1.out_ready) begin
                if (nw < 8) begin
                    chk(m ? "v_addr" : "h_addr", bus1.out_addr, m ? exp_v_addr[nw] : exp_h_addr[nw]);
                    chk(m ? "v_data" : "h_data", bus1.out_data, m ? exp_v_data[nw] : exp_h_data[nw]);
                end
                nw++;
            end
            if (bus1.in_valid && bus1.in_ready) begin
                if (m && idx == 4)  chk("v_no_words_row0", 64'(nw), 64'd0);
                if (m && idx == 12) chk("v_words_before_row3", 64'(nw), 64'd4);
                idx++;
            end
            if (done) begin
                ndone++;
                finished = 1;
            end
            if (stop_words != 0 && nw == stop_words) return;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        bus1.in_valid = 1'b0;
        chk("frame_timeout", finished, 1'b1);
        chk("in_ready_after_frame", bus1.in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
            if (bus1.out_valid) extra++;
        end
        chk("word_count", 64'(nw), 64'd8);
        chk("done_pulses", 64'(ndone), 64'd1);
        chk("extra_words", 64'(extra), 64'd0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus1.in_ready, 1'b0);
        chk("rst_out_valid", bus1.out_valid, 1'b0);
        chk("rst_out_addr", bus1.out_addr, 12'd0);
        chk("rst_out_data", bus1.out_data, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;

        run_frame(1'b0, 0, -1, 0);
        run_frame(1'b1, 0, -1, 0);
        run_frame(1'b0, 1, -1, 0);
        run_frame(1'b0, 0, 6, 0);

        run_frame(1'b0, 0, -1, 3);
        rst_n = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", bus1.out_valid, 1'b0);
        chk("mid_rst_out_addr", bus1.out_addr, 12'd0);
        chk("mid_rst_out_data", bus1.out_data, 16'h0000);
        chk("mid_rst_in_ready", bus1.in_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_quiet", bus1.out_valid, 1'b0);
        end
        run_frame(1'b0, 0, -1, 0);

        @(negedge clk);
        start2 = 1'b1;
        mode2  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.in_data  = {8'h10, 8'h00};
        #1;
        chk("ch2_in_ready", bus2.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus2.in_data = {8'h11, 8'h01};
        @(posedge clk);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("ch2_out_valid", bus2.out_valid, 1'b1);
        chk("ch2_out_addr", bus2.out_addr, 12'd0);
        chk("ch2_out_data", bus2.out_data, 32'h1011_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
